dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-port data RAM between two requesters. The CPU memory stage is the load/store port and has priority. A DMA read port serves a frame/sprite fetch engine. A starvation counter guarantees the DMA port forward progress. The block sits between the memory stage and the dataram instance; memory-mapped I/O decode (VGA store, gamepad load) stays in the memory stage.

Parameters:
AW, 32, address width of both requester ports and the RAM port
MAX_WAIT, 4, max consecutive cycles a pending DMA request may be denied; legal range 1..15
CW, 4, width of the starvation counter; must hold MAX_WAIT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request; held with fields stable until cpu_gnt
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  AW  CPU address
cpu_wdata  in  32  CPU store data
cpu_gnt  out  1  access performed this cycle (combinational)
cpu_rvalid  out  1  load data valid on cpu_rdata (registered)
cpu_rdata  out  32  load data
dma_req  in  1  DMA read request; held with dma_addr stable until dma_gnt
dma_addr  in  AW  DMA read address
dma_gnt  out  1  DMA read performed this cycle (combinational)
dma_rvalid  out  1  DMA data valid on dma_rdata (registered)
dma_rdata  out  32  DMA read data
ram_addr  out  AW  RAM address
ram_din  out  32  RAM write data
ram_we  out  1  RAM write enable
ram_dout  in  32  RAM read data, 1-cycle latency from address

Behaviour:
- Reset (rst_n low, asynchronous): cpu_rvalid=0, dma_rvalid=0, wait_cnt=0, stats counters=0.
- gnt, ram_* are combinational from current inputs and wait_cnt; during reset they follow the same equations with wait_cnt=0.
- Grant rule, evaluated each cycle:
  - force_dma = dma_req & (wait_cnt == MAX_WAIT).
  - cpu_gnt = cpu_req & ~force_dma.
  - dma_gnt = dma_req & ~cpu_gnt.
  - At most one grant per cycle.
- RAM drive:
  - ram_addr = dma_addr when dma_gnt, else cpu_addr.
  - ram_din = cpu_wdata.
  - ram_we = cpu_gnt & cpu_we.
  - The DMA port never writes.
- wait_cnt:
  - Increments when dma_req & ~dma_gnt, saturating at MAX_WAIT.
  - Clears to 0 on dma_gnt or when dma_req is low.
- Read return, 1-cycle latency:
  - cpu_rvalid <= cpu_gnt & ~cpu_we.
  - dma_rvalid <= dma_gnt.
  - cpu_rdata = dma_rdata = ram_dout (broadcast); valid only when the matching rvalid is high.
- Stores: no rvalid; the write completes in the grant cycle.
- CPU stall: the CPU pipeline must stall while cpu_req & ~cpu_gnt.
- Back-to-back: a requester may re-request the cycle after its grant. Grants may alternate every cycle. Each rvalid tracks its own grant exactly one cycle later.
- Simultaneous requests, wait_cnt < MAX_WAIT: CPU wins and wait_cnt increments.
- Simultaneous requests, wait_cnt == MAX_WAIT: DMA wins, CPU is stalled one cycle, wait_cnt clears.
- Requester drops req without a grant: no access occurs; no rvalid is produced.
- Reset asserted in the cycle after a read grant: that rvalid is suppressed (data lost); requesters must reissue after reset.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds outputs cpu_stall_cnt[15:0] and dma_grant_cnt[15:0].
  - cpu_stall_cnt increments each cycle with cpu_req & ~cpu_gnt.
  - dma_grant_cnt increments on each dma_gnt.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers do not exist; arbitration is identical.

Test Plan:
- CPU load only, cpu_addr=0x10, RAM holds 0xDEADBEEF: cpu_gnt=1 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; dma_rvalid stays 0.
- CPU store, addr 0x20, data 0x12345678: ram_we=1, ram_addr=0x20, ram_din=0x12345678 in grant cycle; no cpu_rvalid; later DMA read of 0x20 returns 0x12345678.
- CPU and DMA both requesting continuously, MAX_WAIT=4: repeating pattern of 4 CPU grants then 1 DMA grant; wait_cnt sequence 1,2,3,4,0.
- DMA alone, addresses 0x40,0x44,0x48 back-to-back: dma_gnt high 3 consecutive cycles; dma_rvalid high for the following 3 cycles with matching data.
- Reset pulse the cycle after a DMA grant: dma_rvalid=0 and wait_cnt=0 immediately; no stale rvalid after rst_n rises.
- DMEM_ARB_STATS_EN defined, contention case above run 10 cycles from reset: cpu_stall_cnt=2, dma_grant_cnt=2.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter_if                                                            |
// | Requester/RAM bundle for the data-RAM arbiter: CPU port, DMA port, RAM.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dmem_arbiter_if #(
   parameter int AW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [31:0]   cpu_rdata;

   logic          dma_req;
   logic [AW-1:0] dma_addr;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [31:0]   dma_rdata;

   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic          ram_we;
   logic [31:0]   ram_dout;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, ram_dout,
      output cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
             ram_addr, ram_din, ram_we
   );

   // Requester / RAM side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr, ram_dout,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
             ram_addr, ram_din, ram_we
   );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter                                                               |
// | CPU-priority arbiter for the single-port data RAM with a DMA read port     |
// | protected by a starvation counter. DMEM_ARB_STATS_EN adds stall/grant      |
// | statistics outputs.                                                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int MAX_WAIT = 4,
   parameter int CW       = 4
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]    cpu_stall_cnt,
   output logic [15:0]    dma_grant_cnt
`endif
);

   localparam logic [CW-1:0] c_MAX_WAIT = CW'(MAX_WAIT);
   localparam logic [CW-1:0] c_ONE      = CW'(1);

   logic [CW-1:0] r_waitCnt;
   logic          r_cpuRvalid;
   logic          r_dmaRvalid;
   logic          w_forceDma;
   logic          w_cpuGnt;
   logic          w_dmaGnt;
   logic [AW-1:0] w_ramAddr;

   // DMA overrides CPU priority once it has been denied MAX_WAIT cycles in a row
   assign w_forceDma = bus.dma_req & (r_waitCnt == c_MAX_WAIT);
   assign w_cpuGnt   = bus.cpu_req & ~w_forceDma;
   assign w_dmaGnt   = bus.dma_req & ~w_cpuGnt;
   assign w_ramAddr  = w_dmaGnt ? bus.dma_addr : bus.cpu_addr;

   assign bus.cpu_gnt    = w_cpuGnt;
   assign bus.dma_gnt    = w_dmaGnt;
   assign bus.ram_addr   = w_ramAddr;
   assign bus.ram_din    = bus.cpu_wdata;
   assign bus.ram_we     = w_cpuGnt & bus.cpu_we;
   assign bus.cpu_rvalid = r_cpuRvalid;
   assign bus.dma_rvalid = r_dmaRvalid;
   assign bus.cpu_rdata  = bus.ram_dout;
   assign bus.dma_rdata  = bus.ram_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waitCnt   <= '0;
         r_cpuRvalid <= 1'b0;
         r_dmaRvalid <= 1'b0;
      end else begin
         r_cpuRvalid <= w_cpuGnt & ~bus.cpu_we;
         r_dmaRvalid <= w_dmaGnt;
         if (bus.dma_req & ~w_dmaGnt) begin
            if (r_waitCnt != c_MAX_WAIT) begin
               r_waitCnt <= r_waitCnt + c_ONE;
            end
         end else begin
            r_waitCnt <= '0;
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] r_cpuStallCnt;
   logic [15:0] r_dmaGrantCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpuStallCnt <= '0;
         r_dmaGrantCnt <= '0;
      end else begin
         if (bus.cpu_req & ~w_cpuGnt & (r_cpuStallCnt != 16'hFFFF)) begin
            r_cpuStallCnt <= r_cpuStallCnt + 16'd1;
         end
         if (w_dmaGnt & (r_dmaGrantCnt != 16'hFFFF)) begin
            r_dmaGrantCnt <= r_dmaGrantCnt + 16'd1;
         end
      end
   end

   assign cpu_stall_cnt = r_cpuStallCnt;
   assign dma_grant_cnt = r_dmaGrantCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter                                                            |
// | Directed and randomized bench for dmem_arbiter against a reference model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

   localparam int c_MAX_WAIT = 4;

   logic clk;
   logic rst_n;
   int   vecCount;
   int   errCount;

   dmem_arbiter_if #(.AW(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] cpuStallCnt;
   logic [15:0] dmaGrantCnt;
`endif

   dmem_arbiter #(
      .AW       (32),
      .MAX_WAIT (c_MAX_WAIT),
      .CW       (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus)
`ifdef DMEM_ARB_STATS_EN
      ,
      .cpu_stall_cnt (cpuStallCnt),
      .dma_grant_cnt (dmaGrantCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment RAM: one-cycle read latency, read-before-write
   logic [31:0] ramMem [256];
   logic [31:0] refMem [256];

   always @(posedge clk) begin
      if (bus.ram_we) ramMem[bus.ram_addr[9:2]] <= bus.ram_din;
      bus.ram_dout <= ramMem[bus.ram_addr[9:2]];
   end

   // Reference model state
   int          denyStreak;
   int          mdlStall;
   int          mdlDgnt;
   logic        expCpuRv;
   logic        expDmaRv;
   logic [31:0] expCpuData;
   logic [31:0] expDmaData;
   logic        lastCg;
   logic        lastDg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle's requests and check the combinational grant/RAM outputs
   task automatic driveCheck(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                             input logic [31:0] cData, input logic dReq, input logic [31:0] dAddr);
      logic dmaOwed;
      bus.cpu_req   = cReq;
      bus.cpu_we    = cWe;
      bus.cpu_addr  = cAddr;
      bus.cpu_wdata = cData;
      bus.dma_req   = dReq;
      bus.dma_addr  = dAddr;
      #1;
      dmaOwed = dReq && (denyStreak >= c_MAX_WAIT);
      lastCg  = cReq && !dmaOwed;
      lastDg  = dReq && !lastCg;
      chk("cpu_gnt", {31'b0, bus.cpu_gnt}, {31'b0, lastCg});
      chk("dma_gnt", {31'b0, bus.dma_gnt}, {31'b0, lastDg});
      chk("ram_we", {31'b0, bus.ram_we}, {31'b0, lastCg && cWe});
      chk("ram_addr", bus.ram_addr, lastDg ? dAddr : cAddr);
      if (lastCg && cWe) chk("ram_din", bus.ram_din, cData);
      expCpuRv   = lastCg && !cWe;
      expDmaRv   = lastDg;
      expCpuData = refMem[cAddr[9:2]];
      expDmaData = refMem[dAddr[9:2]];
      if (lastCg && cWe) refMem[cAddr[9:2]] = cData;
      if (dReq && !lastDg) denyStreak = (denyStreak < c_MAX_WAIT) ? denyStreak + 1 : c_MAX_WAIT;
      else denyStreak = 0;
      if (cReq && !lastCg) mdlStall++;
      if (lastDg) mdlDgnt++;
   endtask

   // Advance to the next falling edge and check the registered read return
   task automatic finishCycle();
      @(posedge clk);
      @(negedge clk);
      chk("cpu_rvalid", {31'b0, bus.cpu_rvalid}, {31'b0, expCpuRv});
      chk("dma_rvalid", {31'b0, bus.dma_rvalid}, {31'b0, expDmaRv});
      if (expCpuRv) chk("cpu_rdata", bus.cpu_rdata, expCpuData);
      if (expDmaRv) chk("dma_rdata", bus.dma_rdata, expDmaData);
`ifdef DMEM_ARB_STATS_EN
      chk("cpu_stall_cnt", {16'b0, cpuStallCnt}, mdlStall[31:0]);
      chk("dma_grant_cnt", {16'b0, dmaGrantCnt}, mdlDgnt[31:0]);
`endif
   endtask

   task automatic cycle(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                        input logic [31:0] cData, input logic dReq, input logic [31:0] dAddr);
      driveCheck(cReq, cWe, cAddr, cData, dReq, dAddr);
      finishCycle();
   endtask

   task automatic clearModel();
      denyStreak = 0;
      mdlStall   = 0;
      mdlDgnt    = 0;
      expCpuRv   = 1'b0;
      expDmaRv   = 1'b0;
   endtask

   initial begin
      logic [9:0]  dmaPattern;
      logic        cpuAct;
      logic        cpuWe;
      logic [31:0] cpuAddr;
      logic [31:0] cpuData;
      logic        dmaAct;
      logic [31:0] dmaAddr;

      vecCount = 0;
      errCount = 0;
      for (int i = 0; i < 256; i++) begin
         ramMem[i] = 32'hA5000000 ^ (i * 32'h01010101);
         refMem[i] = 32'hA5000000 ^ (i * 32'h01010101);
      end
      ramMem[8'h04] = 32'hDEADBEEF;
      refMem[8'h04] = 32'hDEADBEEF;
      clearModel();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_addr = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
      chk("rst_dma_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
      chk("rst_stall_cnt", {16'b0, cpuStallCnt}, 32'd0);
      chk("rst_dgnt_cnt", {16'b0, dmaGrantCnt}, 32'd0);
`endif
      rst_n = 1'b1;

      // Continuous contention from reset: 4 CPU grants then 1 DMA grant
      dmaPattern = '0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 1'b1, 32'h200);
         dmaPattern[i] = lastDg;
      end
      chk("contention_pattern", {22'b0, dmaPattern}, 32'h210);
`ifdef DMEM_ARB_STATS_EN
      chk("stats_stall_10", {16'b0, cpuStallCnt}, 32'd2);
      chk("stats_dgnt_10", {16'b0, dmaGrantCnt}, 32'd2);
`endif
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // CPU load of a known word
      cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
      chk("ld_0x10_data", bus.cpu_rdata, 32'hDEADBEEF);

      // CPU store then DMA read-back
      cycle(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
      chk("dma_readback", bus.dma_rdata, 32'h12345678);

      // DMA back-to-back
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h44);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h48);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Build up some DMA starvation, then reset right after a DMA grant
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h50);
      cycle(1'b1, 1'b1, 32'h34, 32'h0BADF00D, 1'b0, 32'h0);
      driveCheck(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h54);
      @(posedge clk);
      #1;
      chk("pre_rst_dma_rvalid", {31'b0, bus.dma_rvalid}, 32'd1);
      rst_n = 1'b0;
      bus.dma_req = 1'b0;
      #1;
      chk("rst_kill_dma_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
      chk("rst_kill_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
      clearModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      dmaPattern = '0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 32'h64);
         dmaPattern[i] = lastDg;
      end
      chk("post_rst_pattern", {22'b0, dmaPattern}, 32'h10);

      // Randomized traffic; DMA occasionally abandons a pending request
      cpuAct = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuData = '0;
      dmaAct = 1'b0; dmaAddr = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!cpuAct && ($urandom_range(0, 9) < 6)) begin
            cpuAct  = 1'b1;
            cpuWe   = ($urandom_range(0, 2) == 0);
            cpuAddr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            cpuData = $urandom;
         end
         if (!dmaAct && ($urandom_range(0, 9) < 5)) begin
            dmaAct  = 1'b1;
            dmaAddr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
         end
         cycle(cpuAct, cpuWe, cpuAddr, cpuData, dmaAct, dmaAddr);
         if (lastCg) cpuAct = 1'b0;
         if (lastDg) dmaAct = 1'b0;
         else if (dmaAct && ($urandom_range(0, 15) == 0)) dmaAct = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
`default_nettype wire
